rfblackwidow_icfill: RTL and testbench



---
 rtl/rfblackwidow_icfill_pkg.sv | 21 ++
 rtl/rfblackwidow_icfill_if.sv | 12 +
 rtl/rfblackwidow_ic_victim.sv | 13 +
 rtl/rfblackwidow_icfill.sv | 124 ++++++++++++
 tb/tb_rfblackwidow_icfill.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rfblackwidow_icfill_pkg.sv
// rfblackwidow_icfill_pkg: shared sizes, fill FSM states and address helpers for the I$ fill controller
package rfblackwidow_icfill_pkg;
  localparam int LINES        = 128;
  localparam int WAYS         = 4;
  localparam int AWID         = 32;
  localparam int BEATS        = 8;
  localparam int IC_BEATS     = 8;
  localparam int IC_LINE_BITS = 1024;
  localparam int BUS_W        = 128;
  localparam int NDX_W        = 7;
  localparam int WAY_W        = 2;
  localparam int BEAT_W       = 3;
  localparam int TAG_W        = AWID - 7;
  typedef enum logic [2:0] {IDLE, INV, REQ, WRITE, ABORT, HOLD} ic_fill_state_t;
  function automatic logic [NDX_W-1:0] adr_ndx(input logic [AWID-1:0] a);
    return a[13:7];
  endfunction
  function automatic logic [TAG_W-1:0] adr_tag(input logic [AWID-1:0] a);
    return a[AWID-1:7];
  endfunction
endpackage

// File: rtl/rfblackwidow_icfill_if.sv
// rfblackwidow_icfill_if: system bus burst port between the fill controller (master) and memory (slave)
interface rfblackwidow_icfill_if;
  import rfblackwidow_icfill_pkg::*;
  logic             cyc_o;
  logic             stb_o;
  logic [AWID-1:0]  adr_o;
  logic             ack_i;
  logic             err_i;
  logic [BUS_W-1:0] dat_i;
  modport master (output cyc_o, stb_o, adr_o, input ack_i, err_i, dat_i);
  modport slave (input cyc_o, stb_o, adr_o, output ack_i, err_i, dat_i);
endinterface

// File: rtl/rfblackwidow_ic_victim.sv
// rfblackwidow_ic_victim: lowest invalid way in the set, else the round-robin way
module rfblackwidow_ic_victim
  import rfblackwidow_icfill_pkg::*;
(
  input  logic [WAYS-1:0]  col_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic [WAY_W-1:0] way_o
);
  always_comb begin
    way_o = rr_i;
    for (int w = WAYS - 1; w >= 0; w--) way_o = col_i[w] ? way_o : WAY_W'(w);
  end
endmodule

// File: rtl/rfblackwidow_icfill.sv
// rfblackwidow_icfill: I$ miss/fill controller; bursts a line in, writes tag/data/valid, services invalidates
module rfblackwidow_icfill
  import rfblackwidow_icfill_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_i,
  input  logic [AWID-1:0]            miss_adr,
  input  logic                       inv_all,
  input  logic                       inv_line,
  input  logic [AWID-1:0]            inv_adr,
  output logic                       inv_ack,
  rfblackwidow_icfill_if.master      bus,
  output logic                       wr_o,
  output logic [WAY_W-1:0]           wr_way,
  output logic [NDX_W-1:0]           wr_ndx,
  output logic [TAG_W-1:0]           wr_tag,
  output logic [IC_LINE_BITS-1:0]    wr_dat,
  output logic [WAYS-1:0][LINES-1:0] valid,
  output logic                       busy_o,
  output logic                       fault_o
);
  ic_fill_state_t             state_q, state_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [NDX_W-1:0]           ndx_q, ndx_d;
  logic [WAY_W-1:0]           way_q, way_d, rr_q, rr_d, victim;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       hold_q, hold_d;
  logic [IC_LINE_BITS-1:0]    line_q;
  logic [WAYS-1:0][LINES-1:0] valid_q;
  logic [WAYS-1:0]            col;
  logic [NDX_W-1:0]           miss_ndx, inv_ndx;
  logic                       beat_ok, unused;
  assign miss_ndx = adr_ndx(miss_adr);
  assign inv_ndx  = adr_ndx(inv_adr);
  assign beat_ok  = state_q == REQ && bus.ack_i && !bus.err_i;
  assign unused   = ^{miss_adr[6:0], inv_adr[AWID-1:14], inv_adr[6:0]};
  always_comb begin
    col = '0;
    for (int w = 0; w < WAYS; w++) col[w] = valid_q[w][miss_ndx];
  end
  rfblackwidow_ic_victim u_victim (.col_i(col), .rr_i(rr_q), .way_o(victim));
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    ndx_d   = ndx_q;
    way_d   = way_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (inv_all || inv_line) begin
          state_d = INV;
          ndx_d   = inv_ndx;
        end else if (miss_i) begin
          state_d = REQ;
          tag_d   = adr_tag(miss_adr);
          ndx_d   = miss_ndx;
          way_d   = victim;
          beat_d  = '0;
        end
      end
      INV: state_d = IDLE;
      REQ: begin
        if (bus.err_i) state_d = ABORT;
        else if (bus.ack_i) begin
          beat_d  = beat_q + 1'b1;
          state_d = beat_q == BEAT_W'(IC_BEATS - 1) ? WRITE : REQ;
          rr_d    = beat_q == BEAT_W'(IC_BEATS - 1) ? rr_q + 1'b1 : rr_q;
        end
      end
      WRITE, ABORT: begin
        state_d = HOLD;
        hold_d  = 1'b0;
      end
      HOLD: begin
        hold_d  = 1'b1;
        state_d = hold_q ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      ndx_q   <= '0;
      way_q   <= '0;
      beat_q  <= '0;
      rr_q    <= '0;
      hold_q  <= 1'b0;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      ndx_q   <= ndx_d;
      way_q   <= way_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      if (beat_ok) line_q[{beat_q, 7'b0} +: BUS_W] <= bus.dat_i;
      if (state_q == IDLE && state_d == INV) begin
        if (inv_all) valid_q <= '0;
        else for (int w = 0; w < WAYS; w++) valid_q[w][inv_ndx] <= 1'b0;
      end
      // leaving REQ: completed line becomes valid, an aborted victim is left invalid
      if (state_q == REQ && state_d != REQ) valid_q[way_q][ndx_q] <= state_d == WRITE;
    end
  end
  assign bus.cyc_o = state_q == REQ;
  assign bus.stb_o = state_q == REQ;
  assign bus.adr_o = {tag_q, beat_q, 4'h0};
  assign wr_o      = state_q == WRITE;
  assign wr_way    = way_q;
  assign wr_ndx    = ndx_q;
  assign wr_tag    = tag_q;
  assign wr_dat    = line_q;
  assign valid     = valid_q;
  assign busy_o    = state_q != IDLE;
  assign fault_o   = state_q == ABORT;
  assign inv_ack   = state_q == INV;
endmodule

// File: tb/tb_rfblackwidow_icfill.sv
// tb_rfblackwidow_icfill: scoreboarded bench for the I$ fill controller with a valid/rr reference model
module tb_rfblackwidow_icfill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miss_i = 1'b0, inv_all = 1'b0, inv_line = 1'b0;
  logic [31:0] miss_adr = '0, inv_adr = '0;
  logic inv_ack, wr_o, busy_o, fault_o;
  logic [1:0] wr_way;
  logic [6:0] wr_ndx;
  logic [24:0] wr_tag;
  logic [1023:0] wr_dat;
  logic [3:0][127:0] valid;
  logic [3:0][127:0] mv;
  int mrr;
  int total = 0, bad = 0;
  logic [127:0] sb[$];

  rfblackwidow_icfill_if bus ();

  rfblackwidow_icfill dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .miss_adr(miss_adr),
    .inv_all(inv_all), .inv_line(inv_line), .inv_adr(inv_adr), .inv_ack(inv_ack),
    .bus(bus), .wr_o(wr_o), .wr_way(wr_way), .wr_ndx(wr_ndx), .wr_tag(wr_tag),
    .wr_dat(wr_dat), .valid(valid), .busy_o(busy_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  function automatic int model_victim(input logic [6:0] ndx);
    for (int w = 0; w < 4; w++) if (!mv[w][ndx]) return w;
    return mrr;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; miss_i = 0; inv_all = 0; inv_line = 0;
    bus.ack_i = 0; bus.err_i = 0; bus.dat_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mv = '0; mrr = 0; sb.delete();
  endtask

  // one miss from IDLE through HOLD; err_beat/rst_beat < 0 disables that event
  task automatic run_fill(input logic [31:0] adr, input int stall_max, input int err_beat,
                          input int rst_beat, output int way);
    logic [6:0] ndx;
    logic [24:0] tag;
    logic [127:0] d;
    logic [31:0] ea;
    int mw, st;
    bit aborted;
    ndx = adr[13:7]; tag = adr[31:7];
    mw = model_victim(ndx);
    way = -1; aborted = 0;
    miss_i = 1; miss_adr = adr;
    @(negedge clk);
    miss_i = 0; miss_adr = $urandom;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL fill_busy got=%b exp=1", busy_o); end
    for (int b = 0; b < 8; b++) begin
      st = stall_max > 0 ? int'($urandom_range(stall_max, 0)) : 0;
      repeat (st) @(negedge clk);
      ea = {tag, b[2:0], 4'h0};
      total++; if (bus.cyc_o !== 1'b1 || bus.stb_o !== 1'b1) begin bad++; $display("FAIL beat_cyc b=%0d got=%b%b exp=11", b, bus.cyc_o, bus.stb_o); end
      total++; if (bus.adr_o !== ea) begin bad++; $display("FAIL beat_adr b=%0d got=%h exp=%h", b, bus.adr_o, ea); end
      total++; if (wr_o !== 1'b0) begin bad++; $display("FAIL beat_wr b=%0d got=%b exp=0", b, wr_o); end
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        mv = '0; mrr = 0; sb.delete();
        total++; if (bus.cyc_o !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b exp=0", bus.cyc_o); end
        total++; if (valid !== mv) begin bad++; $display("FAIL rst_valid got=%h exp=0", valid); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
          @(negedge clk);
          total++; if (wr_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_after got=wr%b busy%b exp=00", wr_o, busy_o); end
        end
        return;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      bus.ack_i = 1; bus.dat_i = d; bus.err_i = (b == err_beat);
      if (b != err_beat) sb.push_back(d);
      @(negedge clk);
      bus.ack_i = 0; bus.err_i = 0; bus.dat_i = {4{$urandom}};
      if (b == err_beat) begin aborted = 1; break; end
    end
    way = int'(wr_way);
    total++; if (bus.cyc_o !== 1'b0) begin bad++; $display("FAIL end_cyc got=%b exp=0", bus.cyc_o); end
    if (aborted) begin
      mv[mw][ndx] = 1'b0; sb.delete();
      total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL abort_fault got=%b exp=1", fault_o); end
      total++; if (wr_o !== 1'b0) begin bad++; $display("FAIL abort_wr got=%b exp=0", wr_o); end
    end else begin
      mv[mw][ndx] = 1'b1; mrr = (mrr + 1) % 4;
      total++; if (wr_o !== 1'b1) begin bad++; $display("FAIL wr_strobe got=%b exp=1", wr_o); end
      total++; if (wr_ndx !== ndx || wr_tag !== tag) begin bad++; $display("FAIL wr_ndx_tag got=%h/%h exp=%h/%h", wr_ndx, wr_tag, ndx, tag); end
      for (int b = 0; b < 8; b++) begin
        d = sb.size() != 0 ? sb.pop_front() : 'x;
        total++; if (wr_dat[b*128 +: 128] !== d) begin bad++; $display("FAIL wr_beat b=%0d got=%h exp=%h", b, wr_dat[b*128 +: 128], d); end
      end
    end
    total++; if (way !== mw) begin bad++; $display("FAIL victim got=%0d exp=%0d", way, mw); end
    total++; if (valid !== mv) begin bad++; $display("FAIL valid_after got=%h exp=%h", valid[mw], mv[mw]); end
    miss_i = 1; bus.ack_i = 1;
    @(negedge clk);
    total++; if (busy_o !== 1'b1 || wr_o !== 1'b0 || fault_o !== 1'b0) begin bad++; $display("FAIL hold1 got=busy%b wr%b flt%b exp=100", busy_o, wr_o, fault_o); end
    @(negedge clk);
    total++; if (busy_o !== 1'b1 || bus.cyc_o !== 1'b0) begin bad++; $display("FAIL hold2 got=busy%b cyc%b exp=10", busy_o, bus.cyc_o); end
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_after got=%b exp=0", busy_o); end
    miss_i = 0; bus.ack_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b%b exp=00", bus.cyc_o, bus.stb_o); end
    total++; if (bus.adr_o !== 32'h0) begin bad++; $display("FAIL reset_adr got=%h exp=0", bus.adr_o); end
    total++; if (wr_o !== 1'b0 || inv_ack !== 1'b0 || fault_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL reset_ctl got=%b%b%b%b exp=0000", wr_o, inv_ack, fault_o, busy_o); end
    total++; if (valid !== '0) begin bad++; $display("FAIL reset_valid got=%h exp=0", valid); end
    total++; if (wr_dat !== '0 || wr_way !== 2'd0 || wr_tag !== '0 || wr_ndx !== '0) begin bad++; $display("FAIL reset_wr got=%h/%h/%h exp=0", wr_way, wr_ndx, wr_tag); end
  endtask

  task automatic test_basic();
    int w;
    run_fill(32'h0000_1280, 0, -1, -1, w);
    total++; if (w !== 0) begin bad++; $display("FAIL basic_way got=%0d exp=0", w); end
    total++; if (valid[0][7'h25] !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid[0][7'h25]); end
  endtask

  task automatic test_victim_rr();
    int w;
    int exp_w[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_fill((i << 14) | 32'h1280, 0, -1, -1, w);
      total++; if (w !== exp_w[i]) begin bad++; $display("FAIL rr_way i=%0d got=%0d exp=%0d", i, w, exp_w[i]); end
    end
  endtask

  task automatic test_err();
    int w;
    run_fill(32'h0004_1280, 0, 3, -1, w);
    total++; if (w !== 2) begin bad++; $display("FAIL err_way got=%0d exp=2", w); end
    total++; if (valid[2][7'h25] !== 1'b0) begin bad++; $display("FAIL err_valid got=%b exp=0", valid[2][7'h25]); end
    run_fill(32'h0008_1280, 0, -1, -1, w);
    total++; if (w !== 2) begin bad++; $display("FAIL err_refill got=%0d exp=2", w); end
  endtask

  task automatic test_inv();
    int w;
    run_fill(32'h0000_1300, 0, -1, -1, w);
    @(negedge clk);
    inv_line = 1; inv_adr = 32'hABCD_1280;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mv[i][7'h25] = 1'b0;
    total++; if (inv_ack !== 1'b1) begin bad++; $display("FAIL invl_ack got=%b exp=1", inv_ack); end
    total++; if (valid !== mv) begin bad++; $display("FAIL invl_valid got=%h exp=%h", valid[0], mv[0]); end
    inv_line = 0;
    @(negedge clk);
    total++; if (inv_ack !== 1'b0) begin bad++; $display("FAIL invl_pulse got=%b exp=0", inv_ack); end
    total++; if (valid[0][7'h26] !== 1'b1) begin bad++; $display("FAIL invl_other got=%b exp=1", valid[0][7'h26]); end
    inv_all = 1; miss_i = 1; miss_adr = 32'h0000_2280;
    @(negedge clk);
    mv = '0;
    total++; if (inv_ack !== 1'b1 || bus.cyc_o !== 1'b0) begin bad++; $display("FAIL inva_first got=ack%b cyc%b exp=10", inv_ack, bus.cyc_o); end
    total++; if (valid !== '0) begin bad++; $display("FAIL inva_valid got=%h exp=0", valid); end
    inv_all = 0;
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL inva_idle got=%b exp=0", busy_o); end
    run_fill(32'h0000_2280, 0, -1, -1, w);
    total++; if (w !== 0) begin bad++; $display("FAIL inva_fill got=%0d exp=0", w); end
  endtask

  task automatic test_stall();
    int w;
    for (int i = 0; i < 4; i++) run_fill($urandom, 5, -1, -1, w);
  endtask

  task automatic test_rst_mid();
    int w;
    run_fill(32'h0000_1280, 2, -1, 5, w);
    run_fill(32'h0000_1280, 0, -1, -1, w);
    total++; if (w !== 0) begin bad++; $display("FAIL rstmid_refill got=%0d exp=0", w); end
  endtask

  initial begin
    bus.ack_i = 0; bus.err_i = 0; bus.dat_i = '0;
    mv = '0; mrr = 0;
    test_reset();
    test_basic();
    test_victim_rr();
    test_err();
    test_inv();
    test_stall();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
